led_blink_multi: RTL

Parametrised successor to the single-channel RGB blinker. It drives CHANNELS LED outputs, each independently configurable as OFF, ON (PWM-dimmed), BLINK or BREATHE. Timing comes from a shared tick prescaler and a shared PWM counter. It sits between the PLL-clocked core and the LED pads, and a valid/ready config port lets a future controller reprogram channels at runtime.

---
 rtl/led_blink_multi_if.sv | 18 +
 rtl/led_blink_multi.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/led_blink_multi_if.sv
// Config port bundle: a valid/ready request that reprograms one LED channel.
// Ports: valid, chan, mode, period and duty come from the controller; ready comes from the blinker.
// Modports: master is the controller side, slave is the blinker side.
interface led_blink_multi_if #(
  parameter int CH_W        = 2,
  parameter int PERIOD_BITS = 16,
  parameter int PWM_BITS    = 8
);
  logic                   valid;
  logic                   ready;
  logic [CH_W-1:0]        chan;
  logic [1:0]             mode;
  logic [PERIOD_BITS-1:0] period;
  logic [PWM_BITS-1:0]    duty;

  modport master (output valid, output chan, output mode, output period, output duty, input ready);
  modport slave  (input valid, input chan, input mode, input period, input duty, output ready);
endinterface

// File: rtl/led_blink_multi.sv
// Multi-channel LED driver: per channel OFF / ON (PWM) / BLINK / BREATHE, shared tick and PWM counters.
// Ports: clk, rst (async active-low), enable, cfg (config slave), led (registered), tick (timebase pulse).
// Config accepted whenever ready; ready drops for one cycle after each accept. Define LED_ACTIVE_LOW_EN for sink-wired pads.
module led_blink_multi #(
  parameter int CHANNELS       = 3,
  parameter int CLK_HZ         = 24000000,
  parameter int TICK_HZ        = 1000,
  parameter int PWM_BITS       = 8,
  parameter int PERIOD_BITS    = 16,
  parameter int DEFAULT_PERIOD = 500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  led_blink_multi_if.slave    cfg,
  output logic [CHANNELS-1:0] led,
  output logic                tick
);
  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [CHANNELS-1:0] LED_IDLE = '1;
`else
  localparam logic [CHANNELS-1:0] LED_IDLE = '0;
`endif

  if (DIV < 2) begin : g_div_chk
    $error("led_blink_multi: CLK_HZ/TICK_HZ must be at least 2");
  end

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  logic [PW-1:0]       presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick_now;
  logic                ready_q;
  logic                accept;

  mode_e                  mode_q   [CHANNELS];
  logic [PERIOD_BITS-1:0] period_q [CHANNELS];
  logic [PERIOD_BITS-1:0] tcnt_q   [CHANNELS];
  logic [PWM_BITS-1:0]    duty_q   [CHANNELS];
  logic [PWM_BITS-1:0]    level_q  [CHANNELS];
  logic                   phase_q  [CHANNELS];
  logic                   down_q   [CHANNELS];

  logic [CHANNELS-1:0] led_next;
  logic [CHANNELS-1:0] led_q;

  // Tick is combinational from the prescaler so channels see it on the same edge it wraps.
  assign tick_now  = enable && (presc == PW'(DIV - 1));
  assign tick      = tick_now;
  assign accept    = cfg.valid && ready_q;
  assign cfg.ready = ready_q;
  assign led       = led_q;

  function automatic logic pwm_on(input logic [PWM_BITS-1:0] x, input logic [PWM_BITS-1:0] cnt);
    return (cnt < x) || (x == '1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else if (enable) begin
      presc   <= tick_now ? '0 : presc + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Ready never stays low past the cycle after an accept, so back-to-back requests alternate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_q <= 1'b1;
    else      ready_q <= !accept;
  end

  // Per-channel state. An accept for a channel overrides its tick on the same edge.
  // Out-of-range cfg.chan matches no channel, so the handshake completes without effect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        mode_q[c]   <= MODE_BLINK;
        period_q[c] <= PERIOD_BITS'(DEFAULT_PERIOD);
        duty_q[c]   <= '1;
        tcnt_q[c]   <= '0;
        phase_q[c]  <= 1'b0;
        level_q[c]  <= '0;
        down_q[c]   <= 1'b0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (accept && (cfg.chan == CH_W'(c))) begin
          mode_q[c]   <= mode_e'(cfg.mode);
          period_q[c] <= cfg.period;
          duty_q[c]   <= cfg.duty;
          tcnt_q[c]   <= '0;
          phase_q[c]  <= 1'b0;
          level_q[c]  <= '0;
          down_q[c]   <= 1'b0;
        end else if (tick_now) begin
          // Blink: a zero period behaves as one tick per half-period.
          if (tcnt_q[c] == ((period_q[c] == '0) ? '0 : period_q[c] - 1'b1)) begin
            tcnt_q[c]  <= '0;
            phase_q[c] <= !phase_q[c];
          end else begin
            tcnt_q[c]  <= tcnt_q[c] + 1'b1;
          end
          // Breathe: triangle between 0 and duty; each bound is visited for one tick.
          if (duty_q[c] == '0) begin
            level_q[c] <= '0;
            down_q[c]  <= 1'b0;
          end else if (!down_q[c]) begin
            level_q[c] <= level_q[c] + 1'b1;
            if (level_q[c] == duty_q[c] - 1'b1) down_q[c] <= 1'b1;
          end else begin
            level_q[c] <= level_q[c] - 1'b1;
            if (level_q[c] == PWM_BITS'(1)) down_q[c] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    led_next = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (mode_q[c])
        MODE_ON:      led_next[c] = pwm_on(duty_q[c], pwm_cnt);
        MODE_BLINK:   led_next[c] = phase_q[c] && pwm_on(duty_q[c], pwm_cnt);
        MODE_BREATHE: led_next[c] = pwm_on(level_q[c], pwm_cnt);
        default:      led_next[c] = 1'b0;
      endcase
    end
    if (!enable) led_next = '0;
  end

  // Polarity is applied at the output register so the pad sees the idle level straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) led_q <= LED_IDLE;
    else      led_q <= led_next ^ LED_IDLE;
  end
endmodule
